// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared states, framing characters and error codes for uart_cmd_sched
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CMD  = 3'd1,
      DATA = 3'd2,
      CSUM = 3'd3,
      END  = 3'd4,
      HOLD = 3'd5
   } state_e;

   localparam logic [7:0] START_CHAR = 8'h73;
   localparam logic [7:0] END_CHAR   = 8'h65;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT = 2'd1;
   localparam logic [1:0] ERR_END     = 2'd2;
   localparam logic [1:0] ERR_CSUM    = 2'd3;

endpackage

// File: rtl/uart_gap_timer.sv
// rtl/uart_gap_timer.sv - inter-byte gap counter; saturates at the limit and flags expiry
module uart_gap_timer #(
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT_CYC);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Holding at LIMIT instead of wrapping keeps a stuck run from re-arming silently.
   always_comb begin
      cnt_d = cnt_q;
      if (!run || clr) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign expire = run && !clr && (cnt_q == LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_cmd_sched.sv
// rtl/uart_cmd_sched.sv - UART frame sequencer presenting whole commands on valid/ready
// Optional checksum byte before the terminator when UART_CMD_CSUM_EN is defined.
module uart_cmd_sched
   import uart_cmd_pkg::*;
#(
   parameter int DATA_BYTES  = 3,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                    sys_clk,
   input  logic                    rst,
   input  logic                    rx_valid,
   input  logic [7:0]              rx_data,
   output logic                    cmd_valid,
   input  logic                    cmd_ready,
   output logic [7:0]              cmd_id,
   output logic [DATA_BYTES*8-1:0] cmd_data,
   output logic                    frame_err,
   output logic [1:0]              err_code,
   output logic                    overrun,
   output logic                    busy
);

   localparam int DW = DATA_BYTES * 8;
   localparam int CW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(DATA_BYTES - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            cmd_valid_q, cmd_valid_d;
   logic [7:0]      cmd_id_q, cmd_id_d;
   logic [DW-1:0]   cmd_data_q, cmd_data_d;
   logic            frame_err_q, frame_err_d;
   logic [1:0]      err_code_q, err_code_d;
   logic            overrun_q, overrun_d;
   logic            busy_q, busy_d;
`ifdef UART_CMD_CSUM_EN
   logic [7:0]      csum_q, csum_d;
`endif

   logic            discard;
   logic [1:0]      disc_code;
   logic            gap_run;
   logic            expire;

   assign gap_run = (state_q == CMD) || (state_q == DATA) ||
                    (state_q == CSUM) || (state_q == END);

   uart_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap_timer (
      .clk    (sys_clk),
      .rst    (rst),
      .clr    (rx_valid),
      .run    (gap_run),
      .expire (expire)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_id_d    = cmd_id_q;
      cmd_data_d  = cmd_data_q;
      err_code_d  = err_code_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      discard     = 1'b0;
      disc_code   = ERR_NONE;
`ifdef UART_CMD_CSUM_EN
      csum_d      = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (rx_valid && rx_data == START_CHAR) state_d = CMD;
         end
         CMD: begin
            if (rx_valid) begin
               cmd_id_d = rx_data;
               cnt_d    = '0;
`ifdef UART_CMD_CSUM_EN
               csum_d   = rx_data;
`endif
               state_d  = DATA;
            end else if (expire) begin
               discard   = 1'b1;
               disc_code = ERR_TIMEOUT;
            end
         end
         DATA: begin
            if (rx_valid) begin
               cmd_data_d = (cmd_data_q << 8) | DW'(rx_data);
               cnt_d      = cnt_q + 1'b1;
`ifdef UART_CMD_CSUM_EN
               csum_d     = csum_q ^ rx_data;
`endif
               if (cnt_q == LAST_IDX) begin
`ifdef UART_CMD_CSUM_EN
                  state_d = CSUM;
`else
                  state_d = END;
`endif
               end
            end else if (expire) begin
               discard   = 1'b1;
               disc_code = ERR_TIMEOUT;
            end
         end
`ifdef UART_CMD_CSUM_EN
         CSUM: begin
            if (rx_valid) begin
               if (rx_data == csum_q) begin
                  state_d = END;
               end else begin
                  discard   = 1'b1;
                  disc_code = ERR_CSUM;
               end
            end else if (expire) begin
               discard   = 1'b1;
               disc_code = ERR_TIMEOUT;
            end
         end
`endif
         END: begin
            if (rx_valid) begin
               if (rx_data == END_CHAR) begin
                  state_d = HOLD;
               end else begin
                  discard   = 1'b1;
                  disc_code = ERR_END;
               end
            end else if (expire) begin
               discard   = 1'b1;
               disc_code = ERR_TIMEOUT;
            end
         end
         HOLD: begin
            // A start byte landing on the handshake cycle opens the next frame directly.
            if (cmd_valid_q && cmd_ready) begin
               state_d = (rx_valid && rx_data == START_CHAR) ? CMD : IDLE;
            end else if (rx_valid) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (discard) begin
         frame_err_d = 1'b1;
         err_code_d  = disc_code;
         state_d     = IDLE;
      end
      cmd_valid_d = (state_d == HOLD);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cmd_valid_q <= 1'b0;
         cmd_id_q    <= '0;
         cmd_data_q  <= '0;
         frame_err_q <= 1'b0;
         err_code_q  <= ERR_NONE;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
`ifdef UART_CMD_CSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_id_q    <= cmd_id_d;
         cmd_data_q  <= cmd_data_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
         overrun_q   <= overrun_d;
         busy_q      <= busy_d;
`ifdef UART_CMD_CSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_id    = cmd_id_q;
   assign cmd_data  = cmd_data_q;
   assign frame_err = frame_err_q;
   assign err_code  = err_code_q;
   assign overrun   = overrun_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_sched.sv
// tb/tb_uart_cmd_sched.sv - table vectors, corner sequences and random traffic against a frame-level model
module tb_uart_cmd_sched;

   localparam int DB = 3;
   localparam int TO = 20;
   localparam int DW = DB * 8;
`ifdef UART_CMD_CSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif
   localparam int FLEN = DB + 3 + CS;

   logic          sys_clk = 1'b0;
   logic          rst = 1'b1;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          cmd_ready = 1'b0;
   logic          cmd_valid;
   logic [7:0]    cmd_id;
   logic [DW-1:0] cmd_data;
   logic          frame_err;
   logic [1:0]    err_code;
   logic          overrun;
   logic          busy;

   int n_checks = 0;
   int n_errors = 0;

   uart_cmd_sched #(.DATA_BYTES(DB), .TIMEOUT_CYC(TO)) dut (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_id    (cmd_id),
      .cmd_data  (cmd_data),
      .frame_err (frame_err),
      .err_code  (err_code),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #10 sys_clk = ~sys_clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Frame-level model: collect bytes of the frame in progress, judge the frame when complete.
   logic [7:0]    mq[$];
   bit            m_hold;
   logic [7:0]    m_id;
   logic [DW-1:0] m_data;
   logic [1:0]    m_code;
   int            m_gap;
   bit            m_ferr, m_ovr;

   task automatic model_reset();
      mq.delete();
      m_hold = 0; m_id = 0; m_data = 0; m_code = 0; m_gap = 0; m_ferr = 0; m_ovr = 0;
   endtask

   task automatic model_discard(input logic [1:0] c);
      m_ferr = 1; m_code = c; mq.delete();
   endtask

   task automatic model_step(input bit v, input logic [7:0] d, input bit r);
      logic [7:0] x;
      m_ferr = 0; m_ovr = 0;
      if (m_hold) begin
         if (r) begin
            m_hold = 0;
            if (v && d == 8'h73) begin mq.push_back(d); m_gap = 0; end
         end else if (v) begin
            m_ovr = 1;
         end
      end else if (mq.size() == 0) begin
         if (v && d == 8'h73) begin mq.push_back(d); m_gap = 0; end
      end else if (v) begin
         mq.push_back(d);
         m_gap = 0;
         if (CS == 1 && mq.size() == FLEN - 1) begin
            x = 0;
            for (int i = 1; i <= DB + 1; i++) x = x ^ mq[i];
            if (x != mq[FLEN-2]) model_discard(2'd3);
         end else if (mq.size() == FLEN) begin
            if (d == 8'h65) begin
               m_hold = 1; m_id = mq[1]; m_data = 0;
               for (int i = 0; i < DB; i++) m_data = (m_data << 8) | DW'(mq[2+i]);
               mq.delete();
            end else begin
               model_discard(2'd2);
            end
         end
      end else begin
         m_gap++;
         if (m_gap == TO) model_discard(2'd1);
      end
   endtask

   task automatic step(input bit v, input logic [7:0] d, input bit r);
      rx_valid = v; rx_data = d; cmd_ready = r;
      @(posedge sys_clk);
      model_step(v, d, r);
      @(negedge sys_clk);
      chk("cmd_valid", cmd_valid, m_hold);
      chk("busy", busy, m_hold || mq.size() > 0);
      chk("frame_err", frame_err, m_ferr);
      chk("err_code", err_code, m_code);
      chk("overrun", overrun, m_ovr);
      if (m_hold) begin
         chk("cmd_id", cmd_id, m_id);
         chk("cmd_data", cmd_data, m_data);
      end
   endtask

   function automatic logic [7:0] csum_of(input logic [7:0] id, input logic [DW-1:0] data);
      logic [7:0] x = id;
      for (int i = 0; i < DB; i++) x = x ^ data[8*i +: 8];
      return x;
   endfunction

   task automatic send_frame(input logic [7:0] id, input logic [DW-1:0] data, input bit r);
      step(1, 8'h73, r);
      step(1, id, r);
      for (int i = DB - 1; i >= 0; i--) step(1, data[8*i +: 8], r);
      if (CS == 1) step(1, csum_of(id, data), r);
      step(1, 8'h65, r);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".cmd_valid"}, cmd_valid, 0);
      chk({tag, ".cmd_id"}, cmd_id, 0);
      chk({tag, ".cmd_data"}, cmd_data, 0);
      chk({tag, ".frame_err"}, frame_err, 0);
      chk({tag, ".err_code"}, err_code, 0);
      chk({tag, ".overrun"}, overrun, 0);
      chk({tag, ".busy"}, busy, 0);
   endtask

   typedef struct {
      bit            v;
      logic [7:0]    d;
      bit            r;
      bit            valid;
      bit            busy;
      bit            ferr;
      logic [1:0]    code;
      bit            ovr;
      logic [7:0]    id;
      logic [DW-1:0] data;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit v, logic [7:0] d, bit val, bit bsy, bit fe, logic [1:0] c,
                               logic [7:0] id, logic [DW-1:0] data);
      vec_t t;
      t.v = v; t.d = d; t.r = 1; t.valid = val; t.busy = bsy; t.ferr = fe; t.code = c;
      t.ovr = 0; t.id = id; t.data = data;
      return t;
   endfunction

   initial begin
      logic [7:0] id;
      logic [DW-1:0] dat;
      logic [7:0] pend[$];
      int fe_at;
      bit rdy;

      model_reset();
      #3;
      chk_all_zero("reset");
      @(posedge sys_clk);
      @(negedge sys_clk);
      chk_all_zero("reset_held");
      rst = 1'b0;

      // Nominal frame, next frame starting on the handshake cycle, bad terminator, stray bytes.
      tbl.push_back(mk(1, 8'h73, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 8'h41, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 8'h01, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 8'h02, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 8'h03, 0, 1, 0, 0, 0, 0));
`ifdef UART_CMD_CSUM_EN
      tbl.push_back(mk(1, 8'h41, 0, 1, 0, 0, 0, 0));
`endif
      tbl.push_back(mk(1, 8'h65, 1, 1, 0, 0, 8'h41, 24'h010203));
      tbl.push_back(mk(1, 8'h73, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 8'h10, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 8'h73, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 8'h65, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 8'h73, 0, 1, 0, 0, 0, 0));
`ifdef UART_CMD_CSUM_EN
      tbl.push_back(mk(1, 8'h75, 0, 1, 0, 0, 0, 0));
`endif
      tbl.push_back(mk(1, 8'h65, 1, 1, 0, 0, 8'h10, 24'h736573));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 8'h73, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 8'h41, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 8'h01, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 8'h02, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 8'h03, 0, 1, 0, 0, 0, 0));
`ifdef UART_CMD_CSUM_EN
      tbl.push_back(mk(1, 8'h41, 0, 1, 0, 0, 0, 0));
`endif
      tbl.push_back(mk(1, 8'h58, 0, 0, 1, 2, 0, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 2, 0, 0));
      tbl.push_back(mk(1, 8'h65, 0, 0, 0, 2, 0, 0));
      tbl.push_back(mk(1, 8'h22, 0, 0, 0, 2, 0, 0));

      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].d, tbl[i].r);
         chk($sformatf("tbl[%0d].valid", i), cmd_valid, tbl[i].valid);
         chk($sformatf("tbl[%0d].busy", i), busy, tbl[i].busy);
         chk($sformatf("tbl[%0d].ferr", i), frame_err, tbl[i].ferr);
         chk($sformatf("tbl[%0d].code", i), err_code, tbl[i].code);
         chk($sformatf("tbl[%0d].ovr", i), overrun, tbl[i].ovr);
         if (tbl[i].valid) begin
            chk($sformatf("tbl[%0d].id", i), cmd_id, tbl[i].id);
            chk($sformatf("tbl[%0d].data", i), cmd_data, tbl[i].data);
         end
      end

      // Longest legal gap must not time out.
      step(1, 8'h73, 1);
      for (int i = 0; i < TO - 1; i++) step(0, 8'h00, 1);
      chk("max_gap_busy", busy, 1);
      step(1, 8'h41, 1);
      chk("max_gap_no_err", frame_err, 0);
      for (int i = 0; i < DB; i++) step(1, 8'h00, 1);
      if (CS == 1) step(1, 8'h41, 1);
      step(1, 8'h65, 1);
      chk("max_gap_accept", cmd_valid, 1);
      step(0, 8'h00, 1);

      // Stall mid-payload until the gap limit.
      step(1, 8'h73, 1);
      step(1, 8'h41, 1);
      step(1, 8'h01, 1);
      fe_at = -1;
      for (int i = 0; i < TO + 4; i++) begin
         step(0, 8'h00, 1);
         if (frame_err && fe_at < 0) fe_at = i;
      end
      chk("timeout_cycle", fe_at, TO - 1);
      chk("timeout_code", err_code, 1);
      chk("timeout_idle", busy, 0);
      send_frame(8'h42, 24'h0A0B0C, 1);
      chk("after_timeout_valid", cmd_valid, 1);
      chk("after_timeout_data", cmd_data, 24'h0A0B0C);
      step(0, 8'h00, 1);

      // Consumer stalls: extra byte overruns; start byte on handshake reopens a frame.
      send_frame(8'h5A, 24'hA1B2C3, 0);
      chk("hold_valid", cmd_valid, 1);
      step(1, 8'h22, 0);
      chk("overrun_pulse", overrun, 1);
      chk("overrun_data", cmd_data, 24'hA1B2C3);
      step(0, 8'h00, 0);
      chk("overrun_one_cycle", overrun, 0);
      step(1, 8'h73, 1);
      chk("hs_valid_drop", cmd_valid, 0);
      chk("hs_busy", busy, 1);
      chk("hs_no_overrun", overrun, 0);
      step(1, 8'h41, 1);
      step(1, 8'h01, 1);
      step(1, 8'h02, 1);
      step(1, 8'h03, 1);
      if (CS == 1) step(1, 8'h41, 1);
      step(1, 8'h65, 1);
      chk("hs_frame_id", cmd_id, 8'h41);
      chk("hs_frame_data", cmd_data, 24'h010203);
      step(0, 8'h00, 1);

`ifdef UART_CMD_CSUM_EN
      step(1, 8'h73, 1);
      step(1, 8'h41, 1);
      step(1, 8'h01, 1);
      step(1, 8'h02, 1);
      step(1, 8'h03, 1);
      step(1, 8'h44, 1);
      chk("csum_err", frame_err, 1);
      chk("csum_code", err_code, 3);
      step(1, 8'h65, 1);
      chk("csum_no_cmd", cmd_valid, 0);
`endif

      // Reset in the middle of the payload.
      step(1, 8'h73, 1);
      step(1, 8'h41, 1);
      step(1, 8'h01, 1);
      rst = 1'b1;
      #2;
      chk_all_zero("mid_rst_async");
      @(posedge sys_clk);
      @(negedge sys_clk);
      chk_all_zero("mid_rst");
      rst = 1'b0;
      model_reset();
      step(0, 8'h00, 1);
      chk("post_rst_no_err", frame_err, 0);
      send_frame(8'h77, 24'h123456, 1);
      chk("post_rst_valid", cmd_valid, 1);
      chk("post_rst_data", cmd_data, 24'h123456);
      step(0, 8'h00, 1);

      // Random traffic: mostly well-formed frames with corruption, junk, stalls and long gaps.
      for (int it = 0; it < 2500; it++) begin
         rdy = ($urandom_range(0, 3) != 0);
         if (pend.size() == 0) begin
            if ($urandom_range(0, 9) == 0) pend.push_back(8'($urandom));
            id = 8'($urandom);
            for (int i = 0; i < DB; i++) begin
               case ($urandom_range(0, 5))
                  0: dat[8*i +: 8] = 8'h73;
                  1: dat[8*i +: 8] = 8'h65;
                  default: dat[8*i +: 8] = 8'($urandom);
               endcase
            end
            pend.push_back(8'h73);
            pend.push_back(id);
            for (int i = DB - 1; i >= 0; i--) pend.push_back(dat[8*i +: 8]);
            if (CS == 1) pend.push_back(csum_of(id, dat) ^ (($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00));
            pend.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h65);
         end
         if ($urandom_range(0, 60) == 0) begin
            int g = $urandom_range(TO - 2, TO + 1);
            for (int k = 0; k < g; k++) step(0, 8'h00, rdy);
         end
         if ($urandom_range(0, 3) != 0) step(1, pend.pop_front(), rdy);
         else step(0, 8'h00, rdy);
      end

      rx_valid = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
